qracc_sram_arbiter: RTL
=======================

Name: qracc_sram_arbiter

Overview:
- Shares the single digital SRAM port of the QRAcc macro (numRows x numCols) between two requesters: port 0 = host config/debug path, port 1 = weight loader.
- Round-robin arbitration, one outstanding transaction at a time. Read data is routed back to the issuing port.
- Blocks new SRAM accesses while the analog MAC is running.
- Sits between the requesters and the SRAM rq_valid/rq_ready/rd_valid handshake.

Parameters:
- numRows, 128, SRAM rows; addrBits = $clog2(numRows).
- numCols, 32, SRAM word width.
- rdTimeout, 64, maximum cycles spent waiting for read data before abort.

Ports:
- clk  input  1  Clock.
- rst  input  1  Asynchronous reset, active-high.
- req_valid_i  input  2  Per-port request valid.
- req_wr_i  input  2  Per-port request type: 1 = write, 0 = read.
- req_addr_i  input  2*addrBits  Per-port address; port p occupies bits [p*addrBits +: addrBits].
- req_wdata_i  input  2*numCols  Per-port write data, packed the same way.
- req_ready_o  output  2  Per-port request accepted this cycle.
- rsp_valid_o  output  2  Per-port read-data valid, one-cycle pulse.
- rsp_data_o  output  numCols  Read data; valid for the port whose rsp_valid_o is high.
- sram_rq_valid_o  output  1  SRAM request valid.
- sram_rq_wr_o  output  1  SRAM request type.
- sram_addr_o  output  addrBits  SRAM address.
- sram_wr_data_o  output  numCols  SRAM write data.
- sram_rq_ready_i  input  1  SRAM accepts the request.
- sram_rd_valid_i  input  1  SRAM read data valid.
- sram_rd_data_i  input  numCols  SRAM read data.
- mac_busy_i  input  1  MAC in progress; blocks new grants.
- busy_o  output  1  High whenever the FSM is not IDLE.
- err_o  output  1  Sticky error flag; cleared only by rst.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; last_grant = 1, so port 0 wins the first tie; holding registers 0.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - When mac_busy_i = 0 and any req_valid_i is set, grant one port.
  - If only one port is valid, grant it. If both are valid, grant the port != last_grant.
  - req_ready_o[g] is combinational, high in the same cycle.
  - On the handshake, latch wr, addr and wdata for port g plus owner = g; set last_grant = g; go to ISSUE next cycle.
  - When mac_busy_i = 1, req_ready_o = 0 and the FSM stays in IDLE.
- ISSUE:
  - sram_rq_valid_o = 1; sram_rq_wr_o, sram_addr_o and sram_wr_data_o are driven from the holding registers and stay stable until sram_rq_ready_i.
  - On sram_rq_valid_o & sram_rq_ready_i: a write goes to IDLE; a read goes to WAIT_RD and clears the timeout counter.
  - mac_busy_i asserting during ISSUE does not abort; an in-flight transaction always completes.
- WAIT_RD:
  - The timeout counter increments every cycle.
  - On sram_rd_valid_i: capture sram_rd_data_i into rsp_data_o; pulse rsp_valid_o[owner] for exactly one cycle on the next cycle; go to IDLE.
  - If the counter reaches rdTimeout - 1 without sram_rd_valid_i: set err_o, go to IDLE, produce no rsp_valid_o pulse.
- Latency:
  - Request accepted at cycle T → sram_rq_valid_o high from T+1.
  - sram_rd_valid_i at cycle R → rsp_valid_o at R+1.
  - Minimum read = 3 cycles from acceptance to rsp_valid_o when SRAM ready and rd_valid are immediate.
  - Back-to-back: a new grant is possible in the first IDLE cycle after completion, so writes sustain 1 request per 2 cycles.
- rsp_data_o holds its last value until the next captured read.
- Stray rd_valid: sram_rd_valid_i outside WAIT_RD is ignored for data and sets err_o.
- rsp_valid_o and a new grant can occur in the same cycle; this is legal.
- busy_o = (state != IDLE).
- Reset mid-operation (async): sram_rq_valid_o, rsp_valid_o and req_ready_o drop immediately; the transaction is lost; state returns to IDLE; err_o is cleared.
- Addresses are not range-checked; they pass through unchanged.

Test Plan:
- Single write: port0 write addr 5, data 0xDEADBEEF, SRAM ready immediately → req_ready_o = 01 at T; sram_rq_valid_o at T+1 with addr 5 / 0xDEADBEEF; busy_o low at T+2.
- Read routing: port1 read addr 127, SRAM returns 0x12345678 two cycles after accept → rsp_valid_o = 10 for exactly one cycle with rsp_data_o = 0x12345678; rsp_valid_o[0] never pulses.
- Round-robin: both ports hold valid writes continuously for 6 grants → grant order 0,1,0,1,0,1; no port starves.
- MAC block: mac_busy_i high for 10 cycles while port0 is valid → req_ready_o = 0 throughout; grant occurs in the cycle mac_busy_i falls. mac_busy_i rising during ISSUE → the transaction still completes.
- SRAM backpressure and timeout:
  - sram_rq_ready_i held low 5 cycles → request signals stable for all 5 cycles.
  - Read with no rd_valid → err_o set after 64 WAIT_RD cycles, FSM back to IDLE, no rsp_valid_o.
- Reset mid-read: assert rst in WAIT_RD → all outputs 0 asynchronously; after release, a port0 read completes normally and port0 wins the first tie.

Source files
------------

// File: rtl/qracc_sram_arbiter.sv
// rtl/qracc_sram_arbiter.sv - round-robin arbiter sharing the QRAcc SRAM port between host and weight loader
module qracc_sram_arbiter #(
    parameter  int numRows   = 128,
    parameter  int numCols   = 32,
    parameter  int rdTimeout = 64,
    localparam int addrBits  = $clog2(numRows)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid_i,
    input  logic [1:0]            req_wr_i,
    input  logic [2*addrBits-1:0] req_addr_i,
    input  logic [2*numCols-1:0]  req_wdata_i,
    output logic [1:0]            req_ready_o,
    output logic [1:0]            rsp_valid_o,
    output logic [numCols-1:0]    rsp_data_o,
    output logic                  sram_rq_valid_o,
    output logic                  sram_rq_wr_o,
    output logic [addrBits-1:0]   sram_addr_o,
    output logic [numCols-1:0]    sram_wr_data_o,
    input  logic                  sram_rq_ready_i,
    input  logic                  sram_rd_valid_i,
    input  logic [numCols-1:0]    sram_rd_data_i,
    input  logic                  mac_busy_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int cntBits = $clog2(rdTimeout);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;

    logic [1:0]          r_state;
    logic                r_last_grant;
    logic                r_owner;
    logic                r_wr;
    logic [addrBits-1:0] r_addr;
    logic [numCols-1:0]  r_wdata;
    logic [cntBits-1:0]  r_cnt;
    logic [1:0]          r_rsp_valid;
    logic [numCols-1:0]  r_rsp_data;
    logic                r_err;

    logic                w_gnt;
    logic                w_gnt_port;

    // Tie goes to the port that did not win last; ready is gated by rst so it drops at once.
    always_comb begin
        w_gnt_port  = (&req_valid_i) ? ~r_last_grant : req_valid_i[1];
        w_gnt       = (r_state == IDLE) && !mac_busy_i && (|req_valid_i) && !rst;
        req_ready_o = 2'b00;
        if (w_gnt) begin
            req_ready_o[w_gnt_port] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_data   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rsp_valid <= 2'b00;
            if (sram_rd_valid_i && (r_state != WAIT_RD)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_owner      <= w_gnt_port;
                        r_last_grant <= w_gnt_port;
                        r_wr         <= w_gnt_port ? req_wr_i[1] : req_wr_i[0];
                        r_addr       <= w_gnt_port ? req_addr_i[addrBits +: addrBits]
                                                   : req_addr_i[0 +: addrBits];
                        r_wdata      <= w_gnt_port ? req_wdata_i[numCols +: numCols]
                                                   : req_wdata_i[0 +: numCols];
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sram_rq_ready_i) begin
                        r_cnt   <= '0;
                        r_state <= r_wr ? IDLE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (sram_rd_valid_i) begin
                        r_rsp_data           <= sram_rd_data_i;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_state              <= IDLE;
                    end else if (r_cnt == cntBits'(rdTimeout - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sram_rq_valid_o = (r_state == ISSUE);
    assign sram_rq_wr_o    = r_wr;
    assign sram_addr_o     = r_addr;
    assign sram_wr_data_o  = r_wdata;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_data_o      = r_rsp_data;
    assign busy_o          = (r_state != IDLE);
    assign err_o           = r_err;

endmodule
